// File: rtl/forex_pkg.sv
// forex_pkg
// Shared definitions for the FOREX arbitrage engine host front end:
//   - default vertex / weight widths
//   - Avalon word addresses of the edge update port
//   - the edge record passed to the Bellman-Ford container stage
//   - bit positions inside the status word
package forex_pkg;

    localparam int VERT_W_DEF   = 5;
    localparam int WEIGHT_W_DEF = 32;

    localparam logic [2:0] ADDR_EDGE   = 3'd0;
    localparam logic [2:0] ADDR_WEIGHT = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_FLUSH  = 3'd3;

    typedef struct packed {
        logic [VERT_W_DEF-1:0]          src;
        logic [VERT_W_DEF-1:0]          dst;
        logic signed [WEIGHT_W_DEF-1:0] e;
    } edge_upd_t;

    localparam int ST_OVERWRITE = 0;
    localparam int ST_ORPHAN    = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_SELFLOOP  = 3;
    localparam int ST_PEND      = 4;
    localparam int ST_COUNT_LSB = 5;

endpackage

// File: rtl/edge_fifo.sv
// edge_fifo
// Synchronous show-ahead FIFO of edge records. The head entry is visible
// on 'head' whenever the FIFO is not empty. Occupancy is kept in its own
// counter so full/empty never depend on pointer comparison.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   push, din   write request and record
//   pop         consume the head entry (ignored when empty)
//   flush       empty the FIFO; takes priority over push and pop
//   full, empty occupancy flags
//   count       occupancy 0..DEPTH
//   head        head record
module edge_fifo
    import forex_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  edge_upd_t                din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output edge_upd_t                head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    edge_upd_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_CNT);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_update_queue.sv
// edge_update_queue
// Avalon-MM write-side front end of the FOREX arbitrage engine. Pairs the
// two-beat host update (src/dst at address 0, weight at address 1) into an
// edge record, buffers records in edge_fifo and hands them one at a time to
// the Bellman-Ford container stage over valid/ready.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   chipselect, write, read,
//   address, writedata, readdata    Avalon-MM slave (readdata registered)
//   upd_valid, upd_ready            record handshake to the container
//   upd_src, upd_dst, upd_e         head record fields
//   count                           FIFO occupancy
module edge_update_queue
    import forex_pkg::*;
#(
    parameter int VERT_W   = VERT_W_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic                     read,
    input  logic [2:0]               address,
    input  logic [WEIGHT_W-1:0]      writedata,
    output logic [WEIGHT_W-1:0]      readdata,
    output logic                     upd_valid,
    input  logic                     upd_ready,
    output logic [VERT_W-1:0]        upd_src,
    output logic [VERT_W-1:0]        upd_dst,
    output logic [WEIGHT_W-1:0]      upd_e,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                r_pend_valid;
    logic [VERT_W-1:0]   r_pend_src;
    logic [VERT_W-1:0]   r_pend_dst;
    logic [3:0]          r_err;
    logic [WEIGHT_W-1:0] r_readdata;

    logic                w_wr_edge;
    logic                w_wr_weight;
    logic                w_wr_clear;
    logic                w_wr_flush;
    logic                w_rd;
    logic                w_selfloop;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    edge_upd_t           w_din;
    edge_upd_t           w_head;
    logic [WEIGHT_W-1:0] w_status;

    assign w_wr_edge   = chipselect && write && (address == ADDR_EDGE);
    assign w_wr_weight = chipselect && write && (address == ADDR_WEIGHT);
    assign w_wr_clear  = chipselect && write && (address == ADDR_STATUS);
    assign w_wr_flush  = chipselect && write && (address == ADDR_FLUSH);
    assign w_rd        = chipselect && read;

    assign w_selfloop = w_wr_weight && r_pend_valid && (r_pend_src == r_pend_dst);
    assign w_push     = w_wr_weight && r_pend_valid && !w_selfloop;
    assign w_pop      = upd_valid && upd_ready;

    assign w_din = '{src: r_pend_src, dst: r_pend_dst, e: writedata};

    edge_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_wr_flush),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (w_head)
    );

    // FIFO storage is not reset, so the head fields are masked to zero
    // while nothing is offered; this also keeps them at 0 after reset.
    assign upd_valid = !w_empty;
    assign upd_src   = upd_valid ? w_head.src : '0;
    assign upd_dst   = upd_valid ? w_head.dst : '0;
    assign upd_e     = upd_valid ? w_head.e   : '0;
    assign count     = w_count;
    assign readdata  = r_readdata;

    always_comb begin
        w_status                       = '0;
        w_status[3:0]                  = r_err;
        w_status[ST_PEND]              = r_pend_valid;
        w_status[ST_COUNT_LSB +: CW]   = w_count;
    end

    always_ff @(posedge clk) begin
        if (reset || w_wr_flush) begin
            r_pend_valid <= 1'b0;
        end else if (w_wr_edge) begin
            r_pend_valid <= 1'b1;
        end else if (w_wr_weight) begin
            r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_edge) begin
            r_pend_src <= writedata[2*VERT_W-1:VERT_W];
            r_pend_dst <= writedata[VERT_W-1:0];
        end
    end

    // Only one address is decoded per cycle, so clear and set never collide.
    // A push lost to a same-cycle flush is not an overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            if (w_wr_clear) begin
                r_err <= r_err & ~writedata[3:0];
            end
            if (w_wr_edge && r_pend_valid) begin
                r_err[ST_OVERWRITE] <= 1'b1;
            end
            if (w_wr_weight && !r_pend_valid) begin
                r_err[ST_ORPHAN] <= 1'b1;
            end
            if (w_push && w_full && !w_pop && !w_wr_flush) begin
                r_err[ST_OVERFLOW] <= 1'b1;
            end
            if (w_selfloop) begin
                r_err[ST_SELFLOOP] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= (address == ADDR_STATUS) ? w_status : '0;
        end
    end

endmodule

// File: tb/tb_edge_update_queue.sv
module tb_edge_update_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        upd_valid;
    logic        upd_ready;
    logic [4:0]  upd_src;
    logic [4:0]  upd_dst;
    logic [31:0] upd_e;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_update_queue #(
        .VERT_W   (5),
        .WEIGHT_W (32),
        .DEPTH    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_src    (upd_src),
        .upd_dst    (upd_dst),
        .upd_e      (upd_e),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One Avalon write; returns at the negedge after the sampling edge.
    task automatic av_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic av_rd_status(output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 3'd2;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic push_rec(input int s, input int t, input logic [31:0] e);
        av_wr(3'd0, 32'((s << 5) | t));
        av_wr(3'd1, e);
    endtask

    logic [31:0] st;

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; upd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(upd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_src", 32'(upd_src), 32'd0);
        chk("rst_e", upd_e, 32'd0);
        chk("rst_rdata", readdata, 32'd0);
        reset = 1'b0;

        // Single record, 1-cycle latency, immediate drain
        upd_ready = 1'b1;
        av_wr(3'd0, 32'h0000_0043);
        chk("lat_pre_valid", 32'(upd_valid), 32'd0);
        av_wr(3'd1, 32'hFFFF_FF80);
        chk("lat_valid", 32'(upd_valid), 32'd1);
        chk("lat_src", 32'(upd_src), 32'd2);
        chk("lat_dst", 32'(upd_dst), 32'd3);
        chk("lat_e", upd_e, 32'hFFFF_FF80);
        @(negedge clk);
        chk("lat_drain_valid", 32'(upd_valid), 32'd0);
        chk("lat_drain_count", 32'(count), 32'd0);

        // Overflow: 9 pushes into 8 entries with ready low
        upd_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_rec(i + 1, i + 10, 32'h100 + 32'(i));
        chk("ovf_count", 32'(count), 32'd8);
        av_rd_status(st);
        chk("ovf_status", st, 32'h0000_0104);
        av_wr(3'd2, 32'hF);
        @(negedge clk);
        upd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_valid", 32'(upd_valid), 32'd1);
            chk("ovf_drain_src", 32'(upd_src), 32'(i + 1));
            chk("ovf_drain_dst", 32'(upd_dst), 32'(i + 10));
            chk("ovf_drain_e", upd_e, 32'h100 + 32'(i));
            @(negedge clk);
        end
        chk("ovf_empty_valid", 32'(upd_valid), 32'd0);
        chk("ovf_empty_count", 32'(count), 32'd0);

        // Orphan weight, then overwritten pending src/dst
        av_wr(3'd1, 32'h55);
        chk("orph_valid", 32'(upd_valid), 32'd0);
        av_rd_status(st);
        chk("orph_status", st, 32'h0000_0002);
        av_wr(3'd0, 32'((1 << 5) | 2));
        av_wr(3'd0, 32'((6 << 5) | 7));
        av_rd_status(st);
        chk("ovw_status", st, 32'h0000_0013);
        upd_ready = 1'b0;
        av_wr(3'd1, 32'h1234);
        chk("ovw_valid", 32'(upd_valid), 32'd1);
        chk("ovw_src", 32'(upd_src), 32'd6);
        chk("ovw_dst", 32'(upd_dst), 32'd7);
        chk("ovw_e", upd_e, 32'h1234);
        chk("ovw_count", 32'(count), 32'd1);
        upd_ready = 1'b1;
        @(negedge clk);
        chk("ovw_drain_valid", 32'(upd_valid), 32'd0);
        av_wr(3'd2, 32'hF);

        // Self-loop is rejected; flag clear
        av_wr(3'd0, 32'((4 << 5) | 4));
        av_wr(3'd1, 32'h99);
        chk("self_valid", 32'(upd_valid), 32'd0);
        chk("self_count", 32'(count), 32'd0);
        av_rd_status(st);
        chk("self_status", st, 32'h0000_0008);
        av_wr(3'd2, 32'hF);
        av_rd_status(st);
        chk("clr_status", st, 32'h0000_0000);

        // Full FIFO with a pop on the same cycle as the push
        upd_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_rec(i + 1, i + 16, 32'h200 + 32'(i));
        chk("fullpop_pre_count", 32'(count), 32'd8);
        av_wr(3'd0, 32'((30 << 5) | 31));
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 32'h777;
        upd_ready = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; upd_ready = 1'b0;
        chk("fullpop_count", 32'(count), 32'd8);
        chk("fullpop_head", 32'(upd_src), 32'd2);
        av_rd_status(st);
        chk("fullpop_status", st, 32'h0000_0100);
        upd_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            chk("fullpop_drain_src", 32'(upd_src), (i < 8) ? 32'(i + 1) : 32'd30);
            chk("fullpop_drain_dst", 32'(upd_dst), (i < 8) ? 32'(i + 16) : 32'd31);
            chk("fullpop_drain_e", upd_e, (i < 8) ? 32'h200 + 32'(i) : 32'h777);
            @(negedge clk);
        end
        chk("fullpop_empty", 32'(upd_valid), 32'd0);

        // Flush with records queued and a pending src/dst; flags survive
        upd_ready = 1'b0;
        av_wr(3'd1, 32'h5);
        for (int i = 0; i < 3; i++) push_rec(i + 1, i + 8, 32'(i));
        av_wr(3'd0, 32'((3 << 5) | 5));
        chk("fl_pre_count", 32'(count), 32'd3);
        av_wr(3'd3, 32'h0);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_valid", 32'(upd_valid), 32'd0);
        chk("fl_src", 32'(upd_src), 32'd0);
        av_rd_status(st);
        chk("fl_status", st, 32'h0000_0002);

        // Reset while draining
        for (int i = 0; i < 3; i++) push_rec(i + 1, i + 8, 32'(i));
        av_rd_status(st);
        chk("rmid_status", st, 32'h0000_0062);
        @(negedge clk);
        upd_ready = 1'b1;
        @(negedge clk);
        chk("rmid_count_before", 32'(count), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("rmid_valid", 32'(upd_valid), 32'd0);
        chk("rmid_count", 32'(count), 32'd0);
        chk("rmid_src", 32'(upd_src), 32'd0);
        chk("rmid_e", upd_e, 32'd0);
        chk("rmid_rdata", readdata, 32'd0);
        reset = 1'b0;
        av_rd_status(st);
        chk("rmid_status_after", st, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
